pipe_hazard_ctrl: RTL

Pipeline control block that drives the `hold` and `clear` inputs of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC hold of the 5-stage MIPS core. It detects load-use hazards, squashes wrong-path instructions on a taken branch, and freezes the pipeline while a multi-cycle data-memory access is outstanding. A wait-state counter turns a hung memory access into a sticky error. A saturating counter records total stall cycles for performance analysis.

---
 rtl/pipe_hazard_ctrl_if.sv | 47 ++++
 rtl/pipe_hazard_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard-control bundle between the 5-stage pipeline and
// pipe_hazard_ctrl.
//   master: pipeline side, drives the hazard inputs and consumes the controls.
//   slave : controller side.
//   Inputs : id_rs, id_rt, id_uses_rt, ex_mem_read, ex_wr_reg, ex_branch_taken,
//            mem_req, mem_ready
//   Outputs: pc_hold, {ifid,idex,exmem,memwb}_hold, {ifid,idex,exmem,memwb}_clear,
//            mem_timeout, stall_cycles[CNT_W-1:0]
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_wr_reg;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_hold;
  logic             ifid_hold;
  logic             idex_hold;
  logic             exmem_hold;
  logic             memwb_hold;
  logic             ifid_clear;
  logic             idex_clear;
  logic             exmem_clear;
  logic             memwb_clear;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_wr_reg, ex_branch_taken,
           mem_req, mem_ready,
    input  pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold,
           ifid_clear, idex_clear, exmem_clear, memwb_clear,
           mem_timeout, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_wr_reg, ex_branch_taken,
           mem_req, mem_ready,
    output pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold,
           ifid_clear, idex_clear, exmem_clear, memwb_clear,
           mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hold/clear control for the IF/ID, ID/EX, EX/MEM, MEM/WB
// pipeline registers and the PC of the 5-stage MIPS core.
//   clk, rst_n : clock, asynchronous active-low reset
//   hz (slave) : hazard inputs in, hold/clear controls out (combinational),
//                mem_timeout (sticky, registered), stall_cycles (saturating,
//                registered count of pc_hold cycles)
// Handles load-use bubbles, taken-branch squash, and multi-cycle data-memory
// freezes; a memory access waiting past MEM_TIMEOUT cycles locks into ERROR.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t           state, state_n;
  logic [7:0]       wait_cnt, wait_cnt_n;
  logic [CNT_W-1:0] stall_cnt;
  logic             timeout_q;

  logic lu;
  logic mem_stall;
  // One-hot action selected this cycle; outputs are decoded from these.
  logic act_mem, act_br, act_lu, act_err;

  assign lu = hz.ex_mem_read && (hz.ex_wr_reg != 5'd0) &&
              ((hz.ex_wr_reg == hz.id_rs) ||
               (hz.id_uses_rt && (hz.ex_wr_reg == hz.id_rt)));

  // A dropped mem_req while waiting counts as completion.
  assign mem_stall = hz.mem_req && !hz.mem_ready;

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    act_mem    = 1'b0;
    act_br     = 1'b0;
    act_lu     = 1'b0;
    act_err    = 1'b0;
    unique case (state)
      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          act_mem = 1'b1;
          if (state == RUN) begin
            state_n    = MEM_WAIT;
            wait_cnt_n = 8'd1;
          end else if (wait_cnt == TIMEOUT) begin
            state_n = ERROR;
          end else begin
            wait_cnt_n = wait_cnt + 8'd1;
          end
        end else begin
          // Branch/load-use held behind a memory wait are resolved here, on
          // the release cycle, with normal RUN priority.
          if (hz.ex_branch_taken) act_br = 1'b1;
          else if (lu)            act_lu = 1'b1;
          state_n    = RUN;
          wait_cnt_n = 8'd0;
        end
      end
      ERROR: act_err = 1'b1;
      default: begin
        state_n    = RUN;
        wait_cnt_n = 8'd0;
      end
    endcase
  end

  always_comb begin
    if (!rst_n) begin
      hz.pc_hold     = 1'b0;
      hz.ifid_hold   = 1'b0;
      hz.idex_hold   = 1'b0;
      hz.exmem_hold  = 1'b0;
      hz.memwb_hold  = 1'b0;
      hz.ifid_clear  = 1'b1;
      hz.idex_clear  = 1'b1;
      hz.exmem_clear = 1'b1;
      hz.memwb_clear = 1'b1;
    end else begin
      hz.pc_hold     = act_mem | act_lu | act_err;
      hz.ifid_hold   = act_mem | act_lu | act_err;
      hz.idex_hold   = act_mem | act_err;
      hz.exmem_hold  = act_mem | act_err;
      hz.memwb_hold  = act_err;
      hz.ifid_clear  = act_br;
      hz.idex_clear  = act_br | act_lu;
      hz.exmem_clear = 1'b0;
      hz.memwb_clear = act_mem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      if (state_n == ERROR) timeout_q <= 1'b1;
      if (hz.pc_hold && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign hz.mem_timeout  = timeout_q;
  assign hz.stall_cycles = stall_cnt;

endmodule
